// File: rtl/cpsr_flags_unit_pkg.sv
// Shared definitions for the NZCV flag path: flag bit positions, condition codes
// and small helpers used by both the flags unit and the conditional evaluator.
package cpsr_flags_unit_pkg;

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned CNT_W   = 3;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic [FLAGS_W-1:0] nzcv_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Per-flag masked write: mask bit 0 keeps the current flag.
  function automatic nzcv_t merge_flags(nzcv_t cur, nzcv_t val, nzcv_t mask);
    return (cur & ~mask) | (val & mask);
  endfunction

  function automatic logic cond_passed(logic [3:0] cond, nzcv_t f);
    logic res;
    res = 1'b0;
    unique case (cond)
      COND_EQ: res = f[FLAG_Z];
      COND_NE: res = ~f[FLAG_Z];
      COND_CS: res = f[FLAG_C];
      COND_CC: res = ~f[FLAG_C];
      COND_MI: res = f[FLAG_N];
      COND_PL: res = ~f[FLAG_N];
      COND_VS: res = f[FLAG_V];
      COND_VC: res = ~f[FLAG_V];
      COND_HI: res = f[FLAG_C] & ~f[FLAG_Z];
      COND_LS: res = ~f[FLAG_C] | f[FLAG_Z];
      COND_GE: res = (f[FLAG_N] == f[FLAG_V]);
      COND_LT: res = (f[FLAG_N] != f[FLAG_V]);
      COND_GT: res = ~f[FLAG_Z] & (f[FLAG_N] == f[FLAG_V]);
      COND_LE: res = f[FLAG_Z] | (f[FLAG_N] != f[FLAG_V]);
      COND_AL: res = 1'b1;
      COND_NV: res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cpsr_flags_unit_inflight_counter.sv
// Counts flag-setting instructions between issue and writeback; saturates at
// MAX_INFLIGHT, clears on flush and reports writebacks that find nothing pending.
module cpsr_flags_unit_inflight_counter
  import cpsr_flags_unit_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             wb_valid,
  input  logic             flush,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             underflow
);

  if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > 7) begin : g_bad_param
    $error("MAX_INFLIGHT must be in 1..7");
  end

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec;
  logic             inc_ok;

  assign full      = (cnt_q >= MaxCnt);
  assign dec       = wb_valid & (cnt_q != '0);
  assign underflow = wb_valid & (cnt_q == '0);
  // A same-cycle retire frees the slot, so a full counter may still accept.
  assign inc_ok    = inc & (~full | dec);

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (inc_ok && !dec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc_ok) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cpsr_flags_unit.sv
// Architectural NZCV flag owner: tracks in-flight flag writers, applies masked
// writebacks and MSR writes, and presents flags plus a trust bit to the evaluator.
module cpsr_flags_unit
  import cpsr_flags_unit_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter bit          BYPASS       = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_issue_valid,
  input  logic               in_issue_sets_flags,
  output logic               out_issue_ready,
  input  logic               in_wb_valid,
  input  logic [FLAGS_W-1:0] in_wb_nzcv,
  input  logic [FLAGS_W-1:0] in_wb_mask,
  input  logic               in_msr_we,
  input  logic [FLAGS_W-1:0] in_msr_nzcv,
  output logic               out_msr_ready,
  input  logic               in_flush,
  output logic [FLAGS_W-1:0] out_cpsr,
  output logic               out_flags_valid,
  output logic [2:0]         out_inflight,
  output logic               out_protocol_err
);

  nzcv_t            flags_q, flags_d;
  nzcv_t            wb_merged;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_full;
  logic             underflow;
  logic             inc;

  assign out_issue_ready = ~cnt_full | in_wb_valid;
  assign inc             = in_issue_valid & in_issue_sets_flags & out_issue_ready;

  cpsr_flags_unit_inflight_counter #(
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_inflight_counter (
    .clk      (clk),
    .rst      (rst),
    .inc      (inc),
    .wb_valid (in_wb_valid),
    .flush    (in_flush),
    .cnt      (cnt_q),
    .full     (cnt_full),
    .underflow(underflow)
  );

  assign wb_merged     = merge_flags(flags_q, in_wb_nzcv, in_wb_mask);
  // MSR only lands when nothing older can still overwrite the flags.
  assign out_msr_ready = (cnt_q == '0) & ~in_wb_valid & ~in_flush;

  always_comb begin
    flags_d = flags_q;
    if (in_wb_valid) begin
      flags_d = wb_merged;
    end else if (in_msr_we && out_msr_ready) begin
      flags_d = in_msr_nzcv;
    end
  end

  assign err_d = err_q | underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    out_cpsr = flags_q;
    if (BYPASS && in_wb_valid) begin
      out_cpsr = wb_merged;
    end
  end

  always_comb begin
    out_flags_valid = (cnt_q == '0);
    if (BYPASS && in_wb_valid && (cnt_q == CNT_W'(1))) begin
      out_flags_valid = 1'b1;
    end
  end

  assign out_inflight     = cnt_q;
  assign out_protocol_err = err_q;

endmodule

// File: doc/cpsr_flags_unit.md
Name: cpsr_flags_unit

Overview:
- Owns the architectural NZCV condition flags.
- Drives the in_cpsr input of conditional_evaluator through out_cpsr, and tells issue logic when those flags are trustworthy.
- Tracks in-flight flag-setting instructions between issue and writeback, applies masked flag writebacks and MSR flag writes, and optionally forwards same-cycle writeback flags.
- Sits between the issue/decode stage and the conditional_evaluator.

Parameters:
- MAX_INFLIGHT, 3: maximum number of flag-setting instructions issued but not yet written back (1..7).
- BYPASS, 1: 1 = out_cpsr forwards same-cycle writeback flags; 0 = out_cpsr shows the registered flags only.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_issue_valid  in  1  an instruction issues this cycle.
- in_issue_sets_flags  in  1  the issuing instruction will write flags at writeback (S-bit set and condition passed).
- out_issue_ready  out  1  a flag-setting issue may be accepted this cycle.
- in_wb_valid  in  1  a flag writeback occurs this cycle.
- in_wb_nzcv  in  4  writeback flags {N,Z,C,V}.
- in_wb_mask  in  4  per-flag write enable, same bit order as in_wb_nzcv.
- in_msr_we  in  1  MSR write to the flag field.
- in_msr_nzcv  in  4  MSR flag value.
- out_msr_ready  out  1  MSR write accepted this cycle.
- in_flush  in  1  pipeline flush; squashes younger in-flight instructions.
- out_cpsr  out  4  {N,Z,C,V} presented to conditional_evaluator.
- out_flags_valid  out  1  out_cpsr reflects all older flag writers.
- out_inflight  out  3  current pending count, for debug.
- out_protocol_err  out  1  sticky error: writeback arrived with no pending writer.

Behaviour:
- State: flags_q[3:0] and cnt_q[2:0].
  - Reset: flags_q=0000, cnt_q=0, error flag=0.
  - Resulting outputs after reset: out_cpsr=0000, out_flags_valid=1, out_issue_ready=1, out_msr_ready=1, out_inflight=0, out_protocol_err=0.
- Issue accept:
  - inc = in_issue_valid & in_issue_sets_flags & out_issue_ready.
  - out_issue_ready = (cnt_q < MAX_INFLIGHT) | in_wb_valid. A writeback in the same cycle frees a slot.
  - Issue of non-flag-setting instructions is never blocked by this unit.
- Writeback:
  - dec = in_wb_valid & (cnt_q != 0).
  - flags_d = (flags_q & ~in_wb_mask) | (in_wb_nzcv & in_wb_mask). Flags with mask bit 0 are held.
  - A writeback with in_wb_mask=0000 still decrements cnt_q.
- Counter:
  - cnt_d = cnt_q + inc - dec. No wrap is possible.
  - Simultaneous inc and dec: count unchanged.
- Writeback with cnt_q=0 (underflow):
  - Flags are still written.
  - cnt_q stays 0.
  - out_protocol_err goes 1 the next cycle and stays 1 until rst.
- MSR:
  - out_msr_ready = (cnt_q == 0) & ~in_wb_valid & ~in_flush.
  - When in_msr_we & out_msr_ready, flags_d = in_msr_nzcv (all four bits written).
  - Otherwise the write is ignored. Issue logic must hold in_msr_we until it sees ready.
- Flush:
  - cnt_d = 0 and any same-cycle issue is discarded.
  - A same-cycle writeback belongs to an older instruction, so its flags are still applied.
  - flags_q is otherwise preserved.
- out_cpsr (combinational):
  - BYPASS=1 and in_wb_valid: out_cpsr = flags_d (masked merge).
  - Otherwise: out_cpsr = flags_q.
- out_flags_valid (combinational):
  - (cnt_q == 0), or
  - (BYPASS=1 & in_wb_valid & cnt_q == 1), i.e. the last pending writer is writing back now.
  - Issue logic must not act on conditional_evaluator's result while out_flags_valid=0.
- Latency:
  - Writeback is visible on out_cpsr the same cycle with BYPASS=1, otherwise the next cycle.
  - MSR is visible the next cycle.
- Reset mid-operation: rst overrides every other input in the same edge, including issue, writeback, MSR and flush.
- out_inflight = cnt_q, zero-extended to 3 bits.

Decomposition:
- Shared package:
  - flag bit indices: N=3, Z=2, C=1, V=0.
  - FLAGS_W=4.
  - the condition-code localparams, moved out of the evaluator so both blocks use one definition.
- One sub-module, inflight_counter: saturating up/down counter with flush-to-zero, parameterised by MAX_INFLIGHT. It produces cnt_q, full and the underflow event.
- Flag merge, bypass mux and MSR gating stay in the top-level module.

Test Plan:
1. Reset, then idle -> out_cpsr=0000, out_flags_valid=1, out_inflight=0, out_issue_ready=1.
2. Issue one flag setter; two cycles later writeback nzcv=0100 mask=1111 (BYPASS=1) -> out_flags_valid=0 for the intervening cycles; out_cpsr=0100 and out_flags_valid=1 in the writeback cycle; out_inflight back to 0.
3. With flags_q=1011, writeback nzcv=0100 mask=1110 -> flags_q=0101 (V held).
4. Issue 3 flag setters back-to-back -> out_issue_ready=0 with out_inflight=3. A fourth issue in the same cycle as a writeback is accepted and out_inflight stays 3.
5. Two pending, then in_flush with a simultaneous writeback nzcv=1000 -> out_inflight=0, flags_q=1000. MSR 0011 is rejected in the flush cycle and accepted the next cycle, giving out_cpsr=0011.
6. Writeback with no pending writer -> flags updated, out_inflight stays 0, out_protocol_err=1 until rst. Asserting rst during 2 pending clears everything to reset values.
